// File: rtl/sig_trace_writer_pkg.sv
// sig_trace_writer_pkg
// Definitions shared between the trace writer and the display controller
// that reads the trace window back: window location and size, sample width,
// write-port widths and the capture state encodings.
package sig_trace_writer_pkg;

   localparam logic [11:0] TRACE_BASE  = 12'h559;
   localparam int          TRACE_DEPTH = 320;
   localparam int          SAMPLE_W    = 12;
   localparam int          ADDR_W      = 12;
   localparam int          MEM_W       = 32;

   // Capture states, kept as plain constants so the reader side can decode them
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_HOLD    = 2'd3;

   // Zero-extend a sample to a memory word
   function automatic logic [MEM_W-1:0] sample_to_word(input logic [SAMPLE_W-1:0] s);
      return {{(MEM_W-SAMPLE_W){1'b0}}, s};
   endfunction

endpackage

// File: rtl/sig_trace_writer_if.sv
// sig_trace_writer_if
// Bundles the sample handshake and the trace-memory write port.
//   sample_valid/sample_data/sample_ready : upstream sample stream
//   mem_addr/mem_data/mem_wEn             : dedicated memory write port
// slave  : the trace writer (consumes samples, drives the write port)
// master : the environment (produces samples, observes the write port)
interface sig_trace_writer_if;
   import sig_trace_writer_pkg::*;

   logic                sample_valid;
   logic [SAMPLE_W-1:0] sample_data;
   logic                sample_ready;
   logic [ADDR_W-1:0]   mem_addr;
   logic [MEM_W-1:0]    mem_data;
   logic                mem_wEn;

   modport slave (
      input  sample_valid, sample_data,
      output sample_ready, mem_addr, mem_data, mem_wEn
   );

   modport master (
      output sample_valid, sample_data,
      input  sample_ready, mem_addr, mem_data, mem_wEn
   );

endinterface

// File: rtl/sig_trace_writer_trigger.sv
// trace_trigger
// Rising-edge trigger detector. Remembers the last accepted sample and flags
// a crossing of TRIG_LEVEL (previous below, current at or above). When the
// trigger is disabled every sample is a hit (free-run).
//   clock, reset : system clock, synchronous active-high reset
//   accept_i     : a sample is accepted this cycle (updates prev)
//   sample_i     : current sample
//   trig_en_i    : 1 = edge trigger, 0 = free-run
//   clear_i      : re-arm; prev returns to all-ones
//   trig_hit_o   : combinational hit for the current sample
module trace_trigger
   import sig_trace_writer_pkg::*;
#(
   parameter logic [SAMPLE_W-1:0] TRIG_LEVEL = 12'h800
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                accept_i,
   input  logic [SAMPLE_W-1:0] sample_i,
   input  logic                trig_en_i,
   input  logic                clear_i,
   output logic                trig_hit_o
);

   logic [SAMPLE_W-1:0] prev_q;

   // All-ones prev can never be below the level, so the first sample after
   // arming never counts as a rising edge.
   always_ff @(posedge clock) begin
      if (reset || clear_i) prev_q <= '1;
      else if (accept_i)    prev_q <= sample_i;
   end

   assign trig_hit_o = !trig_en_i ||
                       ((prev_q < TRIG_LEVEL) && (sample_i >= TRIG_LEVEL));

endmodule

// File: rtl/sig_trace_writer.sv
// sig_trace_writer
// Captures one sweep of DEPTH samples into BASE_ADDR..BASE_ADDR+DEPTH-1,
// optionally waiting for a rising-edge trigger, then holds until the next
// frame boundary so the reader never sees a torn trace.
//   clock, reset   : system clock, synchronous active-high reset
//   bus            : sample handshake in, memory write port out (slave side)
//   trig_en_i      : 1 = wait for rising edge, 0 = free-run
//   frame_end_i    : single-cycle end-of-frame pulse
//   busy_o         : sweep in progress (through the last write)
//   capture_done_o : one-cycle pulse alongside the last write
module sig_trace_writer
   import sig_trace_writer_pkg::*;
#(
   parameter logic [ADDR_W-1:0]   BASE_ADDR  = TRACE_BASE,
   parameter int                  DEPTH      = TRACE_DEPTH,
   parameter int                  DECIM      = 1,
   parameter logic [SAMPLE_W-1:0] TRIG_LEVEL = 12'h800
) (
   input  logic               clock,
   input  logic               reset,
   sig_trace_writer_if.slave  bus,
   input  logic               trig_en_i,
   input  logic               frame_end_i,
   output logic               busy_o,
   output logic               capture_done_o
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
   localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DECIM - 1);

   // The window must fit the 12-bit address space, so BASE_ADDR + idx never wraps
   if (int'(BASE_ADDR) + DEPTH > 4096) begin : g_bad_window
      $error("sig_trace_writer: BASE_ADDR + DEPTH exceeds 4096");
   end
   if (DEPTH < 1 || DECIM < 1) begin : g_bad_size
      $error("sig_trace_writer: DEPTH and DECIM must be at least 1");
   end

   logic [1:0]          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DC_W-1:0]     dcnt_q, dcnt_d;
   logic                wen_q, wen_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [MEM_W-1:0]    data_q, data_d;
   logic                done_q, done_d;

   logic                accept;
   logic                trig_hit;
   logic                prev_clear;
   logic                wr;
   logic [IDX_W-1:0]    wr_idx;

   assign bus.sample_ready = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
   assign accept           = bus.sample_valid && bus.sample_ready;

   trace_trigger #(.TRIG_LEVEL(TRIG_LEVEL)) u_trig (
      .clock      (clock),
      .reset      (reset),
      .accept_i   (accept),
      .sample_i   (bus.sample_data),
      .trig_en_i  (trig_en_i),
      .clear_i    (prev_clear),
      .trig_hit_o (trig_hit)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      dcnt_d     = dcnt_q;
      done_d     = 1'b0;
      prev_clear = 1'b0;
      wr         = 1'b0;
      wr_idx     = '0;

      case (state_q)
         ST_IDLE: state_d = ST_ARMED;

         ST_ARMED: begin
            // Trigger sample always lands at index 0, regardless of DECIM
            if (accept && trig_hit) begin
               wr     = 1'b1;
               dcnt_d = '0;
               if (DEPTH == 1) begin
                  done_d  = 1'b1;
                  idx_d   = '0;
                  state_d = ST_HOLD;
               end else begin
                  idx_d   = IDX_W'(1);
                  state_d = ST_CAPTURE;
               end
            end
         end

         ST_CAPTURE: begin
            // Count is compared before incrementing: DECIM-1 skipped accepts,
            // then the DECIM-th one after the last write is written.
            if (accept) begin
               if (dcnt_q == DC_LAST) begin
                  wr     = 1'b1;
                  wr_idx = idx_q;
                  dcnt_d = '0;
                  if (idx_q == IDX_LAST) begin
                     done_d  = 1'b1;
                     idx_d   = '0;
                     state_d = ST_HOLD;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  dcnt_d = dcnt_q + DC_W'(1);
               end
            end
         end

         ST_HOLD: begin
            if (frame_end_i) begin
               prev_clear = 1'b1;
               state_d    = ST_ARMED;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Write port: address/data hold their last value between writes
      wen_d  = wr;
      addr_d = addr_q;
      data_d = data_q;
      if (wr) begin
         addr_d = BASE_ADDR + ADDR_W'(wr_idx);
         data_d = sample_to_word(bus.sample_data);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         dcnt_q  <= '0;
         wen_q   <= 1'b0;
         addr_q  <= BASE_ADDR;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dcnt_q  <= dcnt_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   assign bus.mem_wEn  = wen_q;
   assign bus.mem_addr = addr_q;
   assign bus.mem_data = data_q;
   assign capture_done_o = done_q;
   // The last write shows up the cycle the FSM is already in HOLD; keep busy
   // asserted through it.
   assign busy_o = (state_q == ST_CAPTURE) || done_q;

endmodule

// File: tb/tb_sig_trace_writer.sv
module tb_sig_trace_writer;

   localparam logic [11:0] BASE  = 12'h559;
   localparam int          DEPTH = 320;
   localparam logic [11:0] LVL   = 12'h800;
   localparam int P_IDLE = 0, P_ARM = 1, P_CAP = 2, P_HOLD = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic trig_en = 1'b0;
   logic frame_end = 1'b0;
   logic busy0, busy1, done0, done1;

   sig_trace_writer_if if0();
   sig_trace_writer_if if1();

   sig_trace_writer #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DECIM(1), .TRIG_LEVEL(LVL)) u_dut1 (
      .clock(clock), .reset(reset), .bus(if0), .trig_en_i(trig_en),
      .frame_end_i(frame_end), .busy_o(busy0), .capture_done_o(done0));

   sig_trace_writer #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DECIM(4), .TRIG_LEVEL(LVL)) u_dut4 (
      .clock(clock), .reset(reset), .bus(if1), .trig_en_i(trig_en),
      .frame_end_i(frame_end), .busy_o(busy1), .capture_done_o(done1));

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [11:0] addr;
      logic [31:0] data;
      bit          last;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int checks = 0;
   int fails  = 0;

   // Reference model: abstract sweep state per instance
   int          m_phase[2];
   logic [11:0] m_prev[2];
   int          m_n[2];      // accepts since the trigger sample
   bit          m_pend[2];   // last write issued last cycle

   function automatic int decim_of(int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic int qsize(int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t qfront(int i);
      return (i == 0) ? q0[0] : q1[0];
   endfunction

   function automatic void qpop(int i);
      if (i == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(int i, int k, logic [11:0] d);
      exp_t e;
      e.due  = cyc + 1;
      e.addr = BASE + 12'(k);
      e.data = {20'd0, d};
      e.last = (k == DEPTH - 1);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic step(int i, logic dut_rdy, logic dut_busy, bit v, logic [11:0] d,
                       bit te, bit fe, bit rst, output bit acc);
      bit rdy;
      int k;
      rdy = (m_phase[i] == P_ARM) || (m_phase[i] == P_CAP);
      chk($sformatf("dut%0d sample_ready", i), 32'(dut_rdy), 32'(rdy));
      chk($sformatf("dut%0d busy", i), 32'(dut_busy),
          32'((m_phase[i] == P_CAP) || m_pend[i]));
      m_pend[i] = 1'b0;
      acc = 1'b0;
      if (rst) begin
         m_phase[i] = P_IDLE;
         m_prev[i]  = 12'hFFF;
         return;
      end
      acc = v && rdy;
      case (m_phase[i])
         P_IDLE: m_phase[i] = P_ARM;
         P_ARM: if (acc) begin
            if (!te || (m_prev[i] < LVL && d >= LVL)) begin
               push(i, 0, d);
               m_n[i] = 0;
               m_phase[i] = P_CAP;
            end
            m_prev[i] = d;
         end
         P_CAP: if (acc) begin
            m_n[i]++;
            if (m_n[i] % decim_of(i) == 0) begin
               k = m_n[i] / decim_of(i);
               push(i, k, d);
               if (k == DEPTH - 1) begin
                  m_phase[i] = P_HOLD;
                  m_pend[i]  = 1'b1;
               end
            end
         end
         P_HOLD: if (fe) begin
            m_phase[i] = P_ARM;
            m_prev[i]  = 12'hFFF;
         end
         default: m_phase[i] = P_IDLE;
      endcase
   endtask

   task automatic tick(bit v, logic [11:0] d, bit te, bit fe, bit rst, bit chk_rst,
                       output bit acc0);
      bit a1;
      @(negedge clock);
      if (chk_rst) begin
         chk("dut0 post-reset mem_wEn", 32'(if0.mem_wEn), 32'd0);
         chk("dut0 post-reset capture_done", 32'(done0), 32'd0);
         chk("dut0 post-reset mem_addr", 32'(if0.mem_addr), 32'(BASE));
         chk("dut0 post-reset mem_data", if0.mem_data, 32'd0);
         chk("dut1 post-reset mem_wEn", 32'(if1.mem_wEn), 32'd0);
         chk("dut1 post-reset capture_done", 32'(done1), 32'd0);
         chk("dut1 post-reset mem_addr", 32'(if1.mem_addr), 32'(BASE));
         chk("dut1 post-reset mem_data", if1.mem_data, 32'd0);
      end
      if0.sample_valid = v;  if1.sample_valid = v;
      if0.sample_data  = d;  if1.sample_data  = d;
      trig_en = te; frame_end = fe; reset = rst;
      step(0, if0.sample_ready, busy0, v, d, te, fe, rst, acc0);
      step(1, if1.sample_ready, busy1, v, d, te, fe, rst, a1);
   endtask

   // Monitor: pops the scoreboard whenever a write is presented
   task automatic mon(int i, logic wen, logic [11:0] a, logic [31:0] dt, logic done);
      exp_t e;
      while (qsize(i) > 0) begin
         e = qfront(i);
         if (e.due >= cyc) break;
         checks++; fails++;
         $display("FAIL dut%0d missing write: got none expected addr %h data %h", i, e.addr, e.data);
         qpop(i);
      end
      if (wen) begin
         if (qsize(i) == 0 || qfront(i).due != cyc) begin
            checks++; fails++;
            $display("FAIL dut%0d unexpected write: got addr %h data %h expected none (cycle %0d)",
                     i, a, dt, cyc);
         end else begin
            e = qfront(i);
            qpop(i);
            chk($sformatf("dut%0d mem_addr", i), 32'(a), 32'(e.addr));
            chk($sformatf("dut%0d mem_data", i), dt, e.data);
            chk($sformatf("dut%0d capture_done", i), 32'(done), 32'(e.last));
         end
      end else begin
         chk($sformatf("dut%0d capture_done without write", i), 32'(done), 32'd0);
      end
   endtask

   always @(negedge clock) begin
      mon(0, if0.mem_wEn, if0.mem_addr, if0.mem_data, done0);
      mon(1, if1.mem_wEn, if1.mem_addr, if1.mem_data, done1);
   end

   initial begin
      bit a, te, reached;
      int k;
      logic [11:0] d;
      if0.sample_valid = 1'b0; if1.sample_valid = 1'b0;
      if0.sample_data  = '0;   if1.sample_data  = '0;
      for (int i = 0; i < 2; i++) begin
         m_phase[i] = P_IDLE; m_prev[i] = 12'hFFF; m_n[i] = 0; m_pend[i] = 1'b0;
      end

      tick(0, 12'h0, 0, 0, 1, 0, a);
      tick(0, 12'h0, 0, 0, 1, 0, a);

      // Free-run ramp 0,1,2,... valid every cycle
      k = 0;
      for (int c = 0; c < 1300; c++) begin
         tick(1, 12'(k), 0, 0, 0, c == 0, a);
         if (a) k++;
      end

      // Edge trigger on a ramp crossing the level
      tick(0, 12'h0, 1, 1, 0, 0, a);
      d = 12'h7F0;
      for (int c = 0; c < 1400; c++) begin
         tick(1, d, 1, 0, 0, 0, a);
         d = d + 12'd8;
      end
      // Rising edge offered during HOLD must not be taken
      tick(1, 12'h700, 1, 0, 0, 0, a);
      tick(1, 12'h900, 1, 0, 0, 0, a);
      for (int c = 0; c < 3; c++) tick(0, 12'h0, 1, 0, 0, 0, a);

      // First sample after re-arm is never an edge; 0x7FF -> 0x800 is
      tick(0, 12'h0, 1, 1, 0, 0, a);
      tick(1, 12'h900, 1, 0, 0, 0, a);
      tick(1, 12'h7FF, 1, 0, 0, 0, a);
      tick(1, 12'h800, 1, 0, 0, 0, a);

      // Random gaps, data, trigger mode and stray frame_end pulses
      te = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 63) == 0) te = ~te;
         tick($urandom_range(0, 3) != 0, 12'($urandom), te,
              $urandom_range(0, 39) == 0, 0, 0, a);
      end

      // Run dut0 into a fresh sweep and reset it at idx 100
      reached = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (m_phase[0] == P_CAP && m_n[0] == 100) begin
            reached = 1'b1;
            break;
         end
         tick(1, 12'($urandom), 0, m_phase[0] == P_HOLD, 0, 0, a);
      end
      checks++;
      if (!reached) begin
         fails++;
         $display("FAIL reach idx100: got timeout expected sweep at index 100");
      end
      tick(0, 12'h0, 0, 0, 1, 0, a);
      tick(1, 12'($urandom), 0, 0, 0, 1, a);
      for (int c = 0; c < 1400; c++) tick(1, 12'($urandom), 0, 0, 0, 0, a);

      for (int c = 0; c < 4; c++) tick(0, 12'h0, 0, 0, 0, 0, a);
      chk("dut0 scoreboard drained", 32'(q0.size()), 32'd0);
      chk("dut1 scoreboard drained", 32'(q1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
